// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with PC select, imem handshake,
// IF/ID register and a one-entry skid buffer for load-use holds.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  pc_next_address_sel,
    input  logic [31:0] jal_target,
    input  logic [31:0] jalr_target,
    input  logic [31:0] branch_target,
    input  logic        stall_decode,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins1,
    output logic [31:0] pc1,
    output logic        ins1_valid
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] drain_addr;
    logic [31:0] skid_ins;
    logic [31:0] skid_pc;
    logic        skid_valid;
    logic [2:0]  sel;
    logic        redirect;
    logic        hold;
    logic        accept;
    logic        stuck;
    logic [31:0] target;

    // request/address depend only on registered state, never on imem_ready
    assign imem_req  = (state == FETCH && !skid_valid) || state == DRAIN;
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;

    always_comb begin
        sel      = (pc_next_address_sel > 3'd4) ? 3'd0 : pc_next_address_sel;
        redirect = sel == 3'd1 || sel == 3'd2 || sel == 3'd3;
        hold     = sel == 3'd4;
        accept   = imem_req && imem_ready;
        stuck    = state == FETCH && imem_req && !imem_ready;
        target   = (sel == 3'd1) ? jal_target :
                   (sel == 3'd2) ? jalr_target : branch_target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drain_addr <= 32'h0;
            skid_ins   <= 32'h0;
            skid_pc    <= 32'h0;
            skid_valid <= 1'b0;
            ins1       <= NOP;
            pc1        <= 32'h0;
            ins1_valid <= 1'b0;
        end else begin
            state <= (state == IDLE)  ? FETCH :
                     (state == DRAIN) ? (imem_ready ? FETCH : DRAIN) :
                     (redirect && stuck) ? DRAIN : FETCH;
            if (redirect) begin
                pc         <= target & ~32'h3;
                skid_valid <= 1'b0;
                ins1       <= NOP;
                pc1        <= 32'h0;
                ins1_valid <= 1'b0;
                // remember the abandoned address so its response can be swallowed
                if (stuck) drain_addr <= pc;
            end else if (hold) begin
                if (state == FETCH && accept) begin
                    skid_ins   <= imem_rdata;
                    skid_pc    <= pc;
                    skid_valid <= 1'b1;
                    pc         <= pc + 32'd4;
                end
            end else if (stall_decode) begin
                ins1       <= NOP;
                pc1        <= 32'h0;
                ins1_valid <= 1'b0;
            end else if (state == FETCH && skid_valid) begin
                ins1       <= skid_ins;
                pc1        <= skid_pc;
                ins1_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (state == FETCH && accept) begin
                ins1       <= imem_rdata;
                pc1        <= pc;
                ins1_valid <= 1'b1;
                pc         <= pc + 32'd4;
            end else begin
                ins1       <= NOP;
                pc1        <= 32'h0;
                ins1_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a
// queue-based behavioural model of the fetch rules.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  pc_next_address_sel = 3'd0;
    logic [31:0] jal_target = 32'h0;
    logic [31:0] jalr_target = 32'h0;
    logic [31:0] branch_target = 32'h0;
    logic        stall_decode = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] ins1;
    logic [31:0] pc1;
    logic        ins1_valid;

    int errors = 0;
    int checks = 0;
    bit rand_data = 1'b0;

    // model: mode 0 = first cycle after reset, 1 = fetching, 2 = draining
    int          m_mode;
    logic [31:0] m_pc, m_drain, m_ins1, m_pc1;
    logic        m_valid;
    logic [63:0] m_skid[$];

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .pc_next_address_sel(pc_next_address_sel),
        .jal_target(jal_target), .jalr_target(jalr_target),
        .branch_target(branch_target), .stall_decode(stall_decode),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .ins1(ins1), .pc1(pc1), .ins1_valid(ins1_valid)
    );

    always #5 clk = ~clk;

    function automatic logic m_req();
        return (m_mode == 1) ? (m_skid.size() == 0) : (m_mode == 2);
    endfunction

    function automatic logic [31:0] m_addr();
        return (m_mode == 2) ? m_drain : m_pc;
    endfunction

    task automatic bubble();
        m_ins1 = NOP; m_pc1 = 32'h0; m_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 32'h0; m_drain = 32'h0;
        m_skid.delete();
        bubble();
    endtask

    task automatic model_step();
        logic req, acc;
        logic [2:0] s;
        logic [31:0] t;
        logic [63:0] e;
        int nm;
        if (!rst_n) begin
            model_reset();
            return;
        end
        req = m_req();
        acc = req && imem_ready;
        s   = (pc_next_address_sel > 3'd4) ? 3'd0 : pc_next_address_sel;
        nm  = (m_mode == 0) ? 1 : (m_mode == 2) ? (imem_ready ? 1 : 2) : 1;
        if (s >= 3'd1 && s <= 3'd3) begin
            t = (s == 3'd1) ? jal_target : (s == 3'd2) ? jalr_target : branch_target;
            t[1:0] = 2'b00;
            if (m_mode == 1 && req && !imem_ready) begin
                m_drain = m_pc;
                nm = 2;
            end
            m_pc = t;
            m_skid.delete();
            bubble();
        end else if (s == 3'd4) begin
            if (m_mode == 1 && acc) begin
                m_skid.push_back({imem_rdata, m_pc});
                m_pc = m_pc + 32'd4;
            end
        end else if (stall_decode) begin
            bubble();
        end else if (m_mode == 1 && m_skid.size() > 0) begin
            e = m_skid.pop_front();
            m_ins1 = e[63:32]; m_pc1 = e[31:0]; m_valid = 1'b1;
        end else if (m_mode == 1 && acc) begin
            m_ins1 = imem_rdata; m_pc1 = m_pc; m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end else begin
            bubble();
        end
        m_mode = nm;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("imem_req", {31'h0, imem_req}, {31'h0, m_req()});
        chk("imem_addr", imem_addr, m_addr());
        chk("ins1", ins1, m_ins1);
        chk("pc1", pc1, m_pc1);
        chk("ins1_valid", {31'h0, ins1_valid}, {31'h0, m_valid});
    endtask

    task automatic tick();
        imem_rdata = rand_data ? $urandom : m_addr();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic step(input logic [2:0] s, input logic [31:0] tgt,
                        input logic st, input logic rdy);
        pc_next_address_sel = s;
        jal_target = tgt; jalr_target = tgt; branch_target = tgt;
        stall_decode = st;
        imem_ready = rdy;
        tick();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("lit_reset_req", {31'h0, imem_req}, 32'h0);
        chk("lit_reset_ins1", ins1, NOP);
        rst_n = 1'b1;
        step(0, 0, 0, 1);
        chk("lit_first_req", {31'h0, imem_req}, 32'h1);
        chk("lit_first_addr", imem_addr, 32'h0);
        step(0, 0, 0, 1);
        chk("lit_ins_0", ins1, 32'h0);
        chk("lit_valid_0", {31'h0, ins1_valid}, 32'h1);
        step(0, 0, 0, 1);
        chk("lit_ins_4", ins1, 32'h4);
        chk("lit_pc1_4", pc1, 32'h4);
        repeat (3) begin
            step(0, 0, 0, 0);
            chk("lit_wait_addr", imem_addr, 32'h8);
            chk("lit_wait_valid", {31'h0, ins1_valid}, 32'h0);
        end
        step(0, 0, 0, 1);
        chk("lit_ins_8", ins1, 32'h8);
        step(4, 0, 0, 1);
        chk("lit_hold1_ins", ins1, 32'h8);
        chk("lit_hold2_req", {31'h0, imem_req}, 32'h0);
        step(4, 0, 0, 1);
        chk("lit_hold2_ins", ins1, 32'h8);
        step(0, 0, 0, 1);
        chk("lit_skid_ins", ins1, 32'hC);
        chk("lit_skid_pc1", pc1, 32'hC);
        step(0, 0, 0, 1);
        chk("lit_ins_10", ins1, 32'h10);
        repeat (3) step(0, 0, 0, 1);
        chk("lit_ins_1c", ins1, 32'h1C);
        step(1, 32'h103, 0, 0);
        chk("lit_drain_addr", imem_addr, 32'h20);
        chk("lit_drain_valid", {31'h0, ins1_valid}, 32'h0);
        step(0, 0, 0, 0);
        chk("lit_drain_addr2", imem_addr, 32'h20);
        step(0, 0, 0, 1);
        chk("lit_after_drain_addr", imem_addr, 32'h100);
        chk("lit_after_drain_valid", {31'h0, ins1_valid}, 32'h0);
        step(0, 0, 0, 1);
        chk("lit_ins_100", ins1, 32'h100);
        step(3, 32'h200, 0, 1);
        chk("lit_br_valid", {31'h0, ins1_valid}, 32'h0);
        chk("lit_br_addr", imem_addr, 32'h200);
        step(0, 0, 0, 1);
        chk("lit_ins_200", ins1, 32'h200);
        step(1, 32'hFFFF_FFFF, 0, 1);
        chk("lit_wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 1);
        chk("lit_wrap_ins", ins1, 32'hFFFF_FFFC);
        chk("lit_wrap_next", imem_addr, 32'h0);
        step(0, 0, 0, 1);
        chk("lit_ins_after_wrap", ins1, 32'h0);
        step(0, 0, 1, 1);
        chk("lit_stall_valid", {31'h0, ins1_valid}, 32'h0);
        chk("lit_stall_addr", imem_addr, 32'h4);
        step(0, 0, 0, 1);
        chk("lit_refetch_ins", ins1, 32'h4);
        step(2, 32'h300, 0, 0);
        chk("lit_drain2_addr", imem_addr, 32'h8);
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare();
        chk("lit_async_req", {31'h0, imem_req}, 32'h0);
        chk("lit_async_addr", imem_addr, 32'h0);
        chk("lit_async_ins1", ins1, NOP);
        step(0, 0, 0, 1);
        rst_n = 1'b1;
        step(0, 0, 0, 1);
        chk("lit_restart_addr", imem_addr, 32'h0);
        step(0, 0, 0, 1);
        chk("lit_restart_ins", ins1, 32'h0);

        rand_data = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            int r;
            rst_n = ($urandom_range(0, 299) != 0);
            r = $urandom_range(0, 9);
            pc_next_address_sel = (r < 5) ? 3'd0 : (r == 5) ? 3'd1 : (r == 6) ? 3'd2 :
                                  (r == 7) ? 3'd3 : (r == 8) ? 3'd4 : 3'($urandom_range(5, 7));
            jal_target    = $urandom;
            jalr_target   = $urandom;
            branch_target = $urandom;
            stall_decode  = ($urandom_range(0, 9) == 0);
            imem_ready    = ($urandom_range(0, 9) < 7);
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage RV32I pipeline. It owns the PC register, the next-PC selection driven by the control unit's `pc_next_address_sel`, and the instruction-memory request handshake. It also owns the IF/ID pipeline register that feeds decode (`ins1`/`pc1`), including a one-entry skid buffer that absorbs fetch data arriving during a load-use hold. It consumes `pc_next_address_sel` and `stall_decode` from the control unit and the jump/branch targets computed in stage 2.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`) placed in IF/ID.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pc_next_address_sel` in 3: next-PC select: 0 pc+4, 1 jal, 2 jalr, 3 branch taken, 4 load-use hold.
- `jal_target` in 32: stage-2 jal target.
- `jalr_target` in 32: stage-2 jalr target.
- `branch_target` in 32: stage-2 branch target.
- `stall_decode` in 1: force a bubble into IF/ID this cycle.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, word aligned.
- `imem_ready` in 1: `imem_rdata` is valid this cycle; completes the request.
- `imem_rdata` in 32: fetched instruction.
- `ins1` out 32: IF/ID instruction.
- `pc1` out 32: IF/ID PC.
- `ins1_valid` out 1: `ins1` holds a real instruction (0 means bubble).

## Operation
- FSM states:
  - IDLE: the single cycle after reset release. `imem_req`=0.
  - FETCH: normal fetching.
  - DRAIN: a redirect arrived while a request was outstanding; wait for that request to complete and discard its data.
- IDLE→FETCH unconditionally.
- FETCH: `imem_req` = !`skid_valid`; `imem_addr` = `pc`.
- DRAIN: `imem_req`=1; `imem_addr` = `drain_addr`.
- A fetch completes ("accept") when `imem_req` && `imem_ready`.
- Redirect: sel ∈ {1,2,3}.
  - `pc` ← selected target with bits [1:0] forced to 0.
  - IF/ID ← bubble; `skid_valid` ← 0.
  - Any word accepted this cycle is discarded.
  - If in FETCH with `imem_req`=1 and `imem_ready`=0: `drain_addr` ← old `pc`, go to DRAIN.
  - Redirect while in DRAIN: `pc` updated, remain in DRAIN.
- DRAIN with `imem_ready`=1: discard data, go to FETCH (next request uses `pc`).
- Hold: sel = 4.
  - `ins1`/`pc1`/`ins1_valid` unchanged.
  - If a word is accepted: skid ← {`imem_rdata`, `pc`}, `skid_valid` ← 1, `pc` ← `pc`+4.
  - Otherwise `pc` unchanged.
- Normal: sel = 0, `stall_decode`=0.
  - If `skid_valid`: IF/ID ← skid (valid=1), `skid_valid` ← 0; no request issued this cycle.
  - Else on accept: IF/ID ← {`imem_rdata`, `pc`, 1}, `pc` ← `pc`+4.
  - Else: IF/ID ← bubble, `pc` unchanged.
- `stall_decode`=1 with sel = 0: IF/ID ← bubble; accepted word dropped, `pc` not advanced (refetch); skid contents retained.
- Priority: redirect > hold > `stall_decode` > normal. Sel values 5–7 are treated as 0.
- Bubble = {`ins1`=`NOP`, `pc1`=0, `ins1_valid`=0}.
- PC arithmetic is 32-bit modulo: 0xFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values: `pc`=`RESET_PC`, `ins1`=`NOP`, `pc1`=0, `ins1_valid`=0, `imem_req`=0, `imem_addr`=`RESET_PC`, state IDLE, `skid_valid`=0, `drain_addr`=0.
- `imem_req` and `imem_addr` are functions of registered state only; no combinational path from `imem_ready`.
- Latency is one cycle from accept to `ins1`. A zero-wait memory sustains one instruction per cycle.
- Redirect penalty: the first target instruction appears in `ins1` two cycles after the redirect cycle (zero-wait memory, no drain).
- Reset assertion mid-DRAIN or mid-hold returns all state to reset values immediately; the outstanding request is abandoned.

## Test plan
- Reset release, `imem_ready` tied 1, rdata = addr → `imem_req` rises one cycle after release. `ins1` = 0,4,8… on consecutive cycles with `pc1` equal; `ins1_valid`=1.
- `imem_ready` low for 3 cycles on address 0x8 → `imem_addr` held at 0x8; `ins1_valid`=0 for those cycles. 0x8 appears the cycle after `imem_ready`.
- sel=4 for 2 cycles while a word at 0xC is accepted → `ins1` frozen; `imem_req`=0 during the second hold cycle. Next cycle `ins1`=word@0xC, `pc1`=0xC, followed by 0x10.
- sel=1, `jal_target`=0x103 while 0x20 is outstanding (`imem_ready`=0) → state DRAIN with `imem_addr` staying 0x20. After ready, data is discarded and the next request is 0x100; `ins1_valid`=0 throughout.
- sel=3 and `imem_ready`=1 in the same cycle → that word is dropped, the next request is `branch_target`, and no stale instruction reaches `ins1`.
- `rst_n` pulsed low during DRAIN → outputs at reset values asynchronously, restart fetching from `RESET_PC`.
